// File: rtl/uart_cmd_host.sv
// Command initiator for the UART register/ALU frame protocol: serialises one
// command into protocol bytes and assembles the response with a timeout.
module uart_cmd_host #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int ALU_FN_WIDTH = 4,
  parameter int TIMEOUT_W    = 16,
  parameter int TIMEOUT_CYC  = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_type,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH-1:0]   cmd_op_a,
  input  logic [DATA_WIDTH-1:0]   cmd_op_b,
  input  logic [ALU_FN_WIDTH-1:0] cmd_alu_fun,
  output logic [DATA_WIDTH-1:0]   tx_byte,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  input  logic [DATA_WIDTH-1:0]   rx_byte,
  input  logic                    rx_valid,
  output logic                    rsp_valid,
  output logic [2*DATA_WIDTH-1:0] rsp_data,
  output logic                    rsp_err,
  output logic                    rx_drop
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_RSP, S_DONE} state_t;

  localparam logic [1:0] CMD_REG_WR  = 2'd0;
  localparam logic [1:0] CMD_REG_RD  = 2'd1;
  localparam logic [1:0] CMD_ALU_OP  = 2'd2;
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);

  state_t                  state_q, state_d;
  logic [1:0]              type_q, type_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   op_a_q, op_a_d;
  logic [DATA_WIDTH-1:0]   op_b_q, op_b_d;
  logic [ALU_FN_WIDTH-1:0] fun_q, fun_d;
  logic [1:0]              idx_q, idx_d, idx_nxt;
  logic [1:0]              rx_cnt_q, rx_cnt_d, rx_cnt_inc;
  logic [2*DATA_WIDTH-1:0] rx_buf_q, rx_buf_d;
  logic [TIMEOUT_W-1:0]    tmo_q, tmo_d;
  logic                    cmd_ready_d, tx_valid_d, rsp_valid_d, rsp_err_d, rx_drop_d;
  logic [DATA_WIDTH-1:0]   tx_byte_d;
  logic [2*DATA_WIDTH-1:0] rsp_data_d;
  logic [DATA_WIDTH-1:0]   frame [4];
  logic [1:0]              last_idx, rsp_len;

  function automatic logic [DATA_WIDTH-1:0] header_byte(input logic [1:0] t);
    case (t)
      CMD_REG_WR: header_byte = DATA_WIDTH'(8'hAA);
      CMD_REG_RD: header_byte = DATA_WIDTH'(8'hBB);
      CMD_ALU_OP: header_byte = DATA_WIDTH'(8'hCC);
      default:    header_byte = DATA_WIDTH'(8'hDD);
    endcase
  endfunction

  // Wire image of the latched command plus its length and response size.
  always_comb begin
    frame[0] = header_byte(type_q);
    frame[1] = '0;
    frame[2] = '0;
    frame[3] = '0;
    last_idx = 2'd1;
    rsp_len  = 2'd2;
    case (type_q)
      CMD_REG_WR: begin
        frame[1] = DATA_WIDTH'(addr_q);
        frame[2] = wdata_q;
        last_idx = 2'd2;
        rsp_len  = 2'd0;
      end
      CMD_REG_RD: begin
        frame[1] = DATA_WIDTH'(addr_q);
        rsp_len  = 2'd1;
      end
      CMD_ALU_OP: begin
        frame[1] = op_a_q;
        frame[2] = op_b_q;
        frame[3] = DATA_WIDTH'(fun_q);
        last_idx = 2'd3;
      end
      default: frame[1] = DATA_WIDTH'(fun_q);
    endcase
  end

  assign idx_nxt    = idx_q + 2'd1;
  assign rx_cnt_inc = rx_cnt_q + 2'd1;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    fun_d       = fun_q;
    idx_d       = idx_q;
    rx_cnt_d    = rx_cnt_q;
    rx_buf_d    = rx_buf_q;
    tmo_d       = tmo_q;
    cmd_ready_d = cmd_ready;
    tx_valid_d  = tx_valid;
    tx_byte_d   = tx_byte;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data;
    rsp_err_d   = rsp_err;
    rx_drop_d   = rx_valid && (state_q != S_WAIT_RSP);
    case (state_q)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready) begin
          type_d      = cmd_type;
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          op_a_d      = cmd_op_a;
          op_b_d      = cmd_op_b;
          fun_d       = cmd_alu_fun;
          idx_d       = 2'd0;
          cmd_ready_d = 1'b0;
          tx_valid_d  = 1'b1;
          tx_byte_d   = header_byte(cmd_type);
          state_d     = S_SEND;
        end
      end
      S_SEND: begin
        if (tx_valid && tx_ready) begin
          if (idx_q == last_idx) begin
            tx_valid_d = 1'b0;
            if (type_q == CMD_REG_WR) begin
              rsp_valid_d = 1'b1;
              rsp_data_d  = '0;
              rsp_err_d   = 1'b0;
              state_d     = S_DONE;
            end else begin
              rx_cnt_d = 2'd0;
              rx_buf_d = '0;
              tmo_d    = '0;
              state_d  = S_WAIT_RSP;
            end
          end else begin
            idx_d     = idx_nxt;
            tx_byte_d = frame[idx_nxt];
          end
        end
      end
      S_WAIT_RSP: begin
        // A byte arriving on the expiry cycle takes precedence over the timeout.
        if (rx_valid) begin
          if (rx_cnt_q == 2'd0) rx_buf_d[DATA_WIDTH-1:0] = rx_byte;
          else                  rx_buf_d[2*DATA_WIDTH-1:DATA_WIDTH] = rx_byte;
          rx_cnt_d = rx_cnt_inc;
          tmo_d    = '0;
          if (rx_cnt_inc == rsp_len) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = rx_buf_d;
            rsp_err_d   = 1'b0;
            state_d     = S_DONE;
          end
        end else if (tmo_q == TMO_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = rx_buf_q;
          rsp_err_d   = 1'b1;
          state_d     = S_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: begin
        cmd_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      type_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      fun_q     <= '0;
      idx_q     <= '0;
      rx_cnt_q  <= '0;
      rx_buf_q  <= '0;
      tmo_q     <= '0;
      cmd_ready <= 1'b0;
      tx_valid  <= 1'b0;
      tx_byte   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      rx_drop   <= 1'b0;
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      fun_q     <= fun_d;
      idx_q     <= idx_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_buf_q  <= rx_buf_d;
      tmo_q     <= tmo_d;
      cmd_ready <= cmd_ready_d;
      tx_valid  <= tx_valid_d;
      tx_byte   <= tx_byte_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      rsp_err   <= rsp_err_d;
      rx_drop   <= rx_drop_d;
    end
  end

endmodule

// File: tb/tb_uart_cmd_host.sv
// Self-checking bench for uart_cmd_host: directed and randomized commands
// compared against a frame/response model built from the protocol rules.
module tb_uart_cmd_host;

  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int FW  = 4;
  localparam int TW  = 16;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_type = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [DW-1:0] cmd_op_a = '0;
  logic [DW-1:0] cmd_op_b = '0;
  logic [FW-1:0] cmd_alu_fun = '0;
  logic [DW-1:0] tx_byte;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic [DW-1:0] rx_byte = '0;
  logic          rx_valid = 1'b0;
  logic          rsp_valid;
  logic [2*DW-1:0] rsp_data;
  logic          rsp_err;
  logic          rx_drop;

  int cyc = 0;
  int n_pass = 0;
  int n_fail = 0;
  int n_checks = 0;

  uart_cmd_host #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALU_FN_WIDTH(FW),
    .TIMEOUT_W(TW), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_op_a(cmd_op_a),
    .cmd_op_b(cmd_op_b), .cmd_alu_fun(cmd_alu_fun),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_byte(rx_byte), .rx_valid(rx_valid),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rx_drop(rx_drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one command, collects its frame from the TX side, answers with up
  // to n_rx bytes and checks the completed response and its timing.
  task automatic apply_stimulus(input logic [1:0] t, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, input logic [DW-1:0] a,
                                input logic [DW-1:0] b, input logic [FW-1:0] fun,
                                input int n_rx, input logic [DW-1:0] r0,
                                input logic [DW-1:0] r1, input int mode,
                                input int gap0, input int gap1);
    logic [DW-1:0] exp_tx[$];
    logic [DW-1:0] got[$];
    logic [DW-1:0] rxq[2];
    logic [DW-1:0] held;
    logic [15:0]   exp_data;
    logic          exp_err, hold_pending;
    int n_need, n_send, t_acc, first_xfer, last_xfer, k;
    int start, rx_sent, next_rx_cyc, timer_start, rsp_cyc, exp_cyc;
    bit seen, drop_seen;

    case (t)
      2'd0:    exp_tx = '{8'hAA, {4'h0, addr}, wdata};
      2'd1:    exp_tx = '{8'hBB, {4'h0, addr}};
      2'd2:    exp_tx = '{8'hCC, a, b, {4'h0, fun}};
      default: exp_tx = '{8'hDD, {4'h0, fun}};
    endcase
    n_need = (t == 2'd0) ? 0 : (t == 2'd1) ? 1 : 2;
    n_send = (n_rx < n_need) ? n_rx : n_need;
    rxq[0] = r0;
    rxq[1] = r1;
    exp_data = 16'h0000;
    if (n_send >= 1) exp_data[7:0]  = r0;
    if (n_send >= 2) exp_data[15:8] = r1;
    exp_err = (n_send < n_need);

    k = 0;
    while (!cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check_output("cmd_ready_idle", cmd_ready, 1);
    cmd_type    = t;
    cmd_addr    = addr;
    cmd_wdata   = wdata;
    cmd_op_a    = a;
    cmd_op_b    = b;
    cmd_alu_fun = fun;
    cmd_valid   = 1'b1;
    t_acc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    check_output("cmd_ready_busy", cmd_ready, 0);
    check_output("tx_valid_first", tx_valid, 1);

    first_xfer = -1;
    last_xfer = -1;
    hold_pending = 1'b0;
    held = '0;
    k = 0;
    while (got.size() < exp_tx.size() && k < 100) begin
      case (mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = k[0];
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      if (hold_pending && tx_valid) check_output("tx_hold", tx_byte, held);
      hold_pending = tx_valid && !tx_ready;
      held = tx_byte;
      if (tx_valid && tx_ready) begin
        got.push_back(tx_byte);
        if (first_xfer < 0) first_xfer = cyc;
        last_xfer = cyc;
      end
      @(negedge clk);
      k++;
    end
    tx_ready = 1'b0;
    check_output("tx_count", got.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size(); i++)
      if (i < got.size()) check_output($sformatf("tx_byte%0d", i), got[i], exp_tx[i]);
    if (mode == 0) begin
      check_output("tx_first_cycle", first_xfer, t_acc + 1);
      check_output("tx_last_cycle", last_xfer, t_acc + exp_tx.size());
    end
    check_output("tx_valid_after", tx_valid, 0);

    start = cyc;
    rx_sent = 0;
    next_rx_cyc = start + gap0;
    timer_start = start;
    rsp_cyc = -1;
    seen = 0;
    drop_seen = 0;
    k = 0;
    while (!seen && k < TMO + 40) begin
      if (rsp_valid) begin
        seen = 1;
        rsp_cyc = cyc;
      end else begin
        if (rx_drop) drop_seen = 1;
        if (rx_sent < n_send && cyc == next_rx_cyc) begin
          rx_valid = 1'b1;
          rx_byte = rxq[rx_sent];
          rx_sent++;
          timer_start = cyc + 1;
          next_rx_cyc = cyc + 1 + gap1;
        end else begin
          rx_valid = 1'b0;
          rx_byte = 8'($urandom);
        end
        @(negedge clk);
        k++;
      end
    end
    rx_valid = 1'b0;

    if (n_need == 0)  exp_cyc = start;
    else if (!exp_err) exp_cyc = timer_start;
    else               exp_cyc = timer_start + TMO;
    check_output("rsp_seen", 32'(seen), 1);
    check_output("rsp_cycle", rsp_cyc, exp_cyc);
    check_output("rsp_data", rsp_data, exp_data);
    check_output("rsp_err", rsp_err, exp_err);
    check_output("rx_drop_in_wait", 32'(drop_seen), 0);
    @(negedge clk);
    check_output("rsp_valid_single", rsp_valid, 0);
    check_output("cmd_ready_after", cmd_ready, 1);
    check_output("rsp_data_hold", rsp_data, exp_data);
  endtask

  initial begin
    int ty, nrx, md;
    bit bad;

    // Reset state while rst is held.
    #12;
    check_output("rst_cmd_ready", cmd_ready, 0);
    check_output("rst_tx_valid", tx_valid, 0);
    check_output("rst_tx_byte", tx_byte, 0);
    check_output("rst_rsp_valid", rsp_valid, 0);
    check_output("rst_rsp_data", rsp_data, 0);
    check_output("rst_rsp_err", rsp_err, 0);
    check_output("rst_rx_drop", rx_drop, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_output("cmd_ready_rise", cmd_ready, 1);

    $display("[TB] directed commands");
    apply_stimulus(2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 0, 8'h00, 8'h00, 0, 0, 0);
    apply_stimulus(2'd1, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0, 1, 8'hA7, 8'h00, 0, 2, 0);
    apply_stimulus(2'd2, 4'h0, 8'h00, 8'h10, 8'h20, 4'h0, 2, 8'h30, 8'h00, 0, 1, 1);
    apply_stimulus(2'd2, 4'h0, 8'h00, 8'h10, 8'h20, 4'h0, 2, 8'h30, 8'h00, 1, 0, 0);
    apply_stimulus(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h2, 1, 8'h55, 8'h00, 0, 0, 0);
    apply_stimulus(2'd1, 4'hF, 8'h00, 8'h00, 8'h00, 4'h0, 0, 8'h00, 8'h00, 0, 0, 0);
    apply_stimulus(2'd2, 4'h0, 8'h00, 8'hFF, 8'h01, 4'hF, 2, 8'h00, 8'hE1, 0, TMO - 1, TMO - 1);

    $display("[TB] rx byte while idle is dropped");
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte = 8'h5A;
    @(negedge clk);
    rx_valid = 1'b0;
    check_output("idle_rx_drop", rx_drop, 1);
    check_output("idle_no_rsp", rsp_valid, 0);
    @(negedge clk);
    check_output("idle_rx_drop_pulse", rx_drop, 0);

    $display("[TB] randomized commands");
    for (int i = 0; i < 16; i++) begin
      ty  = $urandom_range(0, 3);
      nrx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1) : 2;
      md  = $urandom_range(0, 2);
      apply_stimulus(2'(ty), 4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                     4'($urandom), nrx, 8'($urandom), 8'($urandom), md,
                     $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("[TB] reset in the middle of a frame");
    while (!cmd_ready) @(negedge clk);
    cmd_type = 2'd0;
    cmd_addr = 4'h9;
    cmd_wdata = 8'h77;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    tx_ready = 1'b1;
    check_output("mid_first_byte", tx_byte, 8'hAA);
    @(negedge clk);
    tx_ready = 1'b0;
    check_output("mid_second_byte", tx_byte, 8'h09);
    #1 rst = 1'b1;
    #1;
    check_output("mid_rst_tx_valid", tx_valid, 0);
    check_output("mid_rst_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_output("mid_rst_ready", cmd_ready, 1);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (rsp_valid || tx_valid) bad = 1;
      @(negedge clk);
    end
    check_output("mid_rst_quiet", 32'(bad), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
